stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the lab stopwatch datapath. It takes debounced button levels and classifies btn_run presses as short or long with an internal hold counter, using the same long-press scheme as fsm_longpush. It then runs a start/pause/lap/clear state machine that drives the time counter's enable and clear, and the display-freeze control. It sits between the debounce/one-pulse front end and the BCD time counter and display mux.

Parameters:
LONG_CYCLES, 4, number of consecutive clk cycles btn_run must be high to qualify as a long press (>=2)
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > LONG_CYCLES

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
btn_run  input  1  debounced level; short press = start/pause, long press = clear
btn_lap  input  1  debounced level; rising edge = lap toggle
tick  input  1  one-cycle time-base pulse (e.g. 100 Hz enable)
count_en  output  1  increment enable to time counter
count_clr  output  1  one-cycle synchronous clear pulse to time counter
lap_hold  output  1  display freeze while in LAP
state  output  2  current FSM state, for debug/LED

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle including mid-press): state=IDLE, hold_cnt=0, lap_prev=0, count_clr=0, lap_hold=0, count_en=0.
- hold_cnt: on each edge, if btn_run=1 then hold_cnt <= min(hold_cnt+1, LONG_CYCLES); else hold_cnt <= 0. It saturates and never wraps.
- long_ev (combinational) = btn_run & (hold_cnt == LONG_CYCLES-1). It fires exactly once per press, on the LONG_CYCLES-th high cycle.
- short_ev (combinational) = ~btn_run & (hold_cnt != 0) & (hold_cnt < LONG_CYCLES). It fires on the first low cycle after a press shorter than LONG_CYCLES. Releasing after a long press produces no event.
- lap_ev = btn_lap & ~lap_prev; lap_prev is registered btn_lap.
- States: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11. Transitions are taken on the clk edge at which the event is high.
- IDLE: short_ev -> RUN. long_ev -> stay IDLE and pulse count_clr. lap_ev is ignored.
- RUN: short_ev -> PAUSE. long_ev -> IDLE with count_clr. lap_ev -> LAP.
- PAUSE: short_ev -> RUN. long_ev -> IDLE with count_clr. lap_ev is ignored.
- LAP: lap_ev -> RUN. short_ev -> PAUSE. long_ev -> IDLE with count_clr.
- Priority: long_ev/short_ev over lap_ev in the same cycle. When both occur, the lap edge is discarded and not deferred.
- count_clr: registered, high for exactly one cycle after every edge that takes a long_ev, in every state.
- lap_hold: registered, equals (next state == LAP). It rises and falls on the same edge as the state change.
- count_en: combinational = tick & (state==RUN | state==LAP). It is 0 in the cycle count_clr is high. The counter keeps running during LAP.
- state output is the state register directly.
- Latency: button-to-state change is 1 edge after the event condition becomes true. Long press: state changes at the LONG_CYCLES-th rising edge with btn_run high.

Optional Feature:
STOPWATCH_LAP_EN.
- Defined: btn_lap, lap_ev, the LAP state and lap_hold function as above.
- Undefined: the lap_prev register and LAP logic are not built, btn_lap is unused, lap_hold is tied 0, and state never takes 2'b11. All other behaviour is identical.

Test Plan:
(LONG_CYCLES=4, STOPWATCH_LAP_EN defined.)
1. rst_n pulsed low mid-press with btn_run=1 -> outputs 0 and state=00 immediately. After rst_n returns high with btn_run still high, the press counts from 0: long_ev comes 4 cycles later and count_clr pulses once.
2. In IDLE, btn_run high 2 cycles then low -> state=01 at the release edge. Subsequent tick pulses appear on count_en.
3. In RUN, btn_run high 6 cycles -> at the 4th high edge state=00 and count_clr=1 for one cycle. Release causes no further state change.
4. In RUN, btn_run high 1 cycle -> state=10. tick pulses give count_en=0. A second short press -> state=01.
5. In RUN, btn_lap rise -> state=11 and lap_hold=1, with count_en still following tick. Second btn_lap rise -> state=01, lap_hold=0. Build without the macro -> lap rise ignored, lap_hold stays 0.
6. In RUN, short release and btn_lap rise in the same cycle -> state=10, lap_hold stays 0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and counter/display control outputs of the stopwatch sequencer.
interface stopwatch_ctrl_if;
  logic       btn_run;
  logic       btn_lap;
  logic       tick;
  logic       count_en;
  logic       count_clr;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    output btn_run, btn_lap, tick,
    input  count_en, count_clr, lap_hold, state
  );

  modport slave (
    input  btn_run, btn_lap, tick,
    output count_en, count_clr, lap_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/pause/lap/clear sequencer with short/long btn_run press classification.
// Optional lap function is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned LONG_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             count_clr_q, clr_nxt;
  logic             lap_hold_q, lap_hold_nxt;
  logic             long_ev, short_ev, lap_ev;

  // Hold counter saturates at LONG_CYCLES so a long press yields exactly one event
  assign long_ev  = bus.btn_run & (hold_cnt == LONG_M1);
  assign short_ev = ~bus.btn_run & (hold_cnt != '0) & (hold_cnt < LONG_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (bus.btn_run) begin
      if (hold_cnt != LONG_MAX) hold_cnt <= hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lap_prev <= 1'b0;
    else        lap_prev <= bus.btn_lap;
  end

  assign lap_ev = bus.btn_lap & ~lap_prev;
`else
  logic unused_lap;
  assign unused_lap = bus.btn_lap;
  assign lap_ev     = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_clr_q <= 1'b0;
      lap_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      count_clr_q <= clr_nxt;
      lap_hold_q  <= lap_hold_nxt;
    end
  end

  // Button events override a coincident lap edge, which is then dropped
  always_comb begin
    state_nxt    = state_q;
    clr_nxt      = 1'b0;
    lap_hold_nxt = 1'b0;
    if (long_ev) begin
      state_nxt = IDLE;
      clr_nxt   = 1'b1;
    end else if (short_ev) begin
      case (state_q)
        IDLE, PAUSE: state_nxt = RUN;
        RUN, LAP:    state_nxt = PAUSE;
        default:     state_nxt = IDLE;
      endcase
    end else if (lap_ev) begin
      case (state_q)
        RUN:     state_nxt = LAP;
        LAP:     state_nxt = RUN;
        default: state_nxt = state_q;
      endcase
    end
`ifdef STOPWATCH_LAP_EN
    lap_hold_nxt = (state_nxt == LAP);
`endif
  end

  assign bus.state     = state_q;
  assign bus.count_clr = count_clr_q;
  assign bus.lap_hold  = lap_hold_q;
  assign bus.count_en  = bus.tick & ~count_clr_q & ((state_q == RUN) | (state_q == LAP));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a cycle model predicts outputs after each edge.
module tb_stopwatch_ctrl;
  localparam int LONG = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] st;
    logic       clr;
    logic       hold;
    logic       en;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.LONG_CYCLES(LONG), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  // reference model state
  logic [1:0] m_state;
  int         m_len;
  logic       m_lap_prev;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = 2'b00;
    m_len      = 0;
    m_lap_prev = 1'b0;
  endtask

  // one clock: drive inputs, predict post-edge outputs, compare after the edge
  task automatic step(input logic run, input logic lap, input logic tk);
    logic       long_ev, short_ev, lap_ev, clr;
    logic [1:0] ns;
    exp_t       e, got;
    bus.btn_run = run;
    bus.btn_lap = lap;
    bus.tick    = tk;
    long_ev  = run && (m_len == LONG - 1);
    short_ev = !run && (m_len > 0) && (m_len < LONG);
    lap_ev   = LAP_EN && lap && !m_lap_prev;
    ns  = m_state;
    clr = 1'b0;
    if (long_ev) begin
      ns  = 2'b00;
      clr = 1'b1;
    end else if (short_ev) begin
      ns = (m_state == 2'b01 || m_state == 2'b11) ? 2'b10 : 2'b01;
    end else if (lap_ev) begin
      if (m_state == 2'b01)      ns = 2'b11;
      else if (m_state == 2'b11) ns = 2'b01;
    end
    m_len      = run ? m_len + 1 : 0;
    m_lap_prev = lap;
    m_state    = ns;
    e.st   = ns;
    e.clr  = clr;
    e.hold = (ns == 2'b11);
    e.en   = tk && (ns == 2'b01 || ns == 2'b11) && !clr;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.state, bus.count_clr, bus.lap_hold, bus.count_en};
    e   = q.pop_front();
    chk("state",     8'(got.st),   8'(e.st));
    chk("count_clr", 8'(got.clr),  8'(e.clr));
    chk("lap_hold",  8'(got.hold), 8'(e.hold));
    chk("count_en",  8'(got.en),   8'(e.en));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 8'(bus.state),     8'h00);
    chk({tag, "_clr"},   8'(bus.count_clr), 8'h00);
    chk({tag, "_hold"},  8'(bus.lap_hold),  8'h00);
    chk({tag, "_en"},    8'(bus.count_en),  8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached before end of test");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bus.btn_run = 1'b0;
    bus.btn_lap = 1'b0;
    bus.tick    = 1'b1;
    model_reset();
    #2;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: reset in the middle of a press, press restarts from zero afterwards
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    bus.tick = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // 2: short press from IDLE starts the watch, ticks pass through
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i[0]);

    // 3: long press in RUN clears and returns to IDLE; release is silent
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // 4: RUN -> PAUSE (ticks gated) -> RUN
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // 5: lap toggle in RUN, counter keeps running while frozen
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // long press from LAP
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // 6: short release coinciding with lap edge in RUN
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // long press from PAUSE, plus press of exactly LONG-1 cycles (still short)
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // random mix of press lengths, lap edges and ticks
    for (int n = 0; n < 60; n++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < int'($urandom_range(1, 3)); i++)
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    if (q.size() != 0) chk("queue_drain", 8'(q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
